note_sequence_player: RTL and testbench



---
 rtl/note_sequence_player.sv | 205 ++++++++++++++++++++
 tb/tb_note_sequence_player.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequence_player.sv
// note_sequence_player
//   Plays the six-symbol note entry sequence (F, mode note, two free notes,
//   G, terminator X) on the tone/note/ok interface of the phrase recognizer.
//   Each symbol is set up on tone/note, then ok is pressed and released.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   start     request to play one sequence (level, sampled every clock)
//   type_sel  01 past, 10 infinitive, 11 future, 00 invalid
//             (named type_sel because 'type' is a SystemVerilog keyword)
//   tone3     tone for free symbol 3
//   note3     note for free symbol 3
//   tone4     tone for free symbol 4
//   note4     note for free symbol 4
//   ok        emulated confirm button
//   tone      tone presented to the recognizer
//   note      note presented to the recognizer (000=X, 001=C ... 111=B)
//   busy      sequence in progress
//   done      one-cycle pulse when the sequence completes
//   err       one-cycle pulse when a start request is rejected
module note_sequence_player #(
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 4,
  parameter int LOW_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] type_sel,
  input  logic       tone3,
  input  logic [2:0] note3,
  input  logic       tone4,
  input  logic [2:0] note4,
  output logic       ok,
  output logic       tone,
  output logic [2:0] note,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SETUP, PRESS, GAP} state_t;

  // Terminal counts: the counter runs 0..N-1 within each phase.
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HIGH_LAST  = 8'(HIGH_CYC - 1);
  localparam logic [7:0] LOW_LAST   = 8'(LOW_CYC - 1);
  localparam logic [2:0] LAST_IDX   = 3'd5;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt, idx_inc;
  logic [7:0] cnt, cnt_nxt;
  logic       ok_nxt, tone_nxt, busy_nxt, done_nxt, err_nxt;
  logic [2:0] note_nxt;
  logic       accept;

  // Request captured at acceptance; later input changes are ignored.
  logic [1:0] cap_type;
  logic       cap_tone3, cap_tone4;
  logic [2:0] cap_note3, cap_note4;

  logic [3:0] sym_inc;  // {tone,note} of the symbol following idx

  assign idx_inc = idx + 3'd1;

  always_comb begin
    sym_inc = 4'b0_000;
    case (idx_inc)
      3'd1: begin
        case (cap_type)
          2'b01:   sym_inc = 4'b1_001;  // C, past
          2'b10:   sym_inc = 4'b1_100;  // F, infinitive
          default: sym_inc = 4'b1_111;  // B, future
        endcase
      end
      3'd2:    sym_inc = {cap_tone3, cap_note3};
      3'd3:    sym_inc = {cap_tone4, cap_note4};
      3'd4:    sym_inc = 4'b0_101;      // G
      default: sym_inc = 4'b0_000;      // X terminator
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    ok_nxt    = ok;
    tone_nxt  = tone;
    note_nxt  = note;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    accept    = 1'b0;

    case (state)
      IDLE: begin
        ok_nxt   = 1'b0;
        tone_nxt = 1'b0;
        note_nxt = 3'b000;
        busy_nxt = 1'b0;
        if (start) begin
          // A zero note would be read as the terminator X, so it is refused.
          if (type_sel == 2'b00 || note3 == 3'b000 || note4 == 3'b000) begin
            err_nxt = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = SETUP;
            busy_nxt  = 1'b1;
            idx_nxt   = 3'd0;
            cnt_nxt   = 8'd0;
            tone_nxt  = 1'b0;
            note_nxt  = 3'b100;  // symbol 0 is always F
          end
        end
      end

      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = PRESS;
          cnt_nxt   = 8'd0;
          ok_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      PRESS: begin
        if (cnt == HIGH_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = 8'd0;
          ok_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      GAP: begin
        if (cnt == LOW_LAST) begin
          cnt_nxt = 8'd0;
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            tone_nxt  = 1'b0;
            note_nxt  = 3'b000;
          end else begin
            // The next symbol appears while ok is still low.
            state_nxt           = SETUP;
            idx_nxt             = idx_inc;
            {tone_nxt, note_nxt} = sym_inc;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state <= IDLE;
      idx   <= 3'd0;
      cnt   <= 8'd0;
      ok    <= 1'b0;
      tone  <= 1'b0;
      note  <= 3'b000;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      ok    <= ok_nxt;
      tone  <= tone_nxt;
      note  <= note_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_type  <= 2'b00;
      cap_tone3 <= 1'b0;
      cap_note3 <= 3'b000;
      cap_tone4 <= 1'b0;
      cap_note4 <= 3'b000;
    end else if (accept) begin
      cap_type  <= type_sel;
      cap_tone3 <= tone3;
      cap_note3 <= note3;
      cap_tone4 <= tone4;
      cap_note4 <= note4;
    end
  end

endmodule

// File: tb/tb_note_sequence_player.sv
// Bench for note_sequence_player. Two instances share all inputs: one with the
// default timing (2/4/4) and one with the shortest timing (1/1/1). Expected
// outputs come from a cycle-offset model: cycle n after the accepting edge lies
// in symbol n/P at position n%P, and ok is high for positions S..S+H-1.
module tb_note_sequence_player;

  localparam int SA = 2, HA = 4, LA = 4, PA = SA + HA + LA;
  localparam int SB = 1, HB = 1, LB = 1, PB = SB + HB + LB;

  logic       clk, reset, start;
  logic [1:0] type_sel;
  logic       tone3, tone4;
  logic [2:0] note3, note4;

  logic       ok_a, tone_a, busy_a, done_a, err_a;
  logic [2:0] note_a;
  logic       ok_b, tone_b, busy_b, done_b, err_b;
  logic [2:0] note_b;

  int n_checks = 0;
  int n_fail   = 0;

  note_sequence_player #(.SETUP_CYC(SA), .HIGH_CYC(HA), .LOW_CYC(LA)) dut_a (
    .clk(clk), .reset(reset), .start(start), .type_sel(type_sel),
    .tone3(tone3), .note3(note3), .tone4(tone4), .note4(note4),
    .ok(ok_a), .tone(tone_a), .note(note_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  note_sequence_player #(.SETUP_CYC(SB), .HIGH_CYC(HB), .LOW_CYC(LB)) dut_b (
    .clk(clk), .reset(reset), .start(start), .type_sel(type_sel),
    .tone3(tone3), .note3(note3), .tone4(tone4), .note4(note4),
    .ok(ok_b), .tone(tone_b), .note(note_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed output bundles {ok,tone,note,busy,done}.
  wire [6:0] obs_a = {ok_a, tone_a, note_a, busy_a, done_a};
  wire [6:0] obs_b = {ok_b, tone_b, note_b, busy_b, done_b};

  // Symbol table of the entry phrase, as {tone,note}.
  function automatic logic [3:0] symbol(int k, logic [1:0] ty, logic t3, logic [2:0] n3,
                                        logic t4, logic [2:0] n4);
    case (k)
      0: return 4'b0_100;
      1: return (ty == 2'b01) ? 4'b1_001 : (ty == 2'b10) ? 4'b1_100 : 4'b1_111;
      2: return {t3, n3};
      3: return {t4, n4};
      4: return 4'b0_101;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [23:0] build_syms(logic [1:0] ty, logic t3, logic [2:0] n3,
                                             logic t4, logic [2:0] n4);
    logic [23:0] s;
    for (int k = 0; k < 6; k++) s[k*4 +: 4] = symbol(k, ty, t3, n3, t4, n4);
    return s;
  endfunction

  // Expected {ok,tone,note,busy,done} n cycles after the accepting edge.
  function automatic logic [6:0] model(int n, int s, int h, int l, logic [23:0] syms);
    int p, k, r;
    logic [6:0] e;
    p = s + h + l;
    e = '0;
    if (n >= 0 && n < 6 * p) begin
      k = n / p;
      r = n % p;
      e[6]   = (r >= s) && (r < s + h);
      e[5:2] = syms[k*4 +: 4];
      e[1]   = 1'b1;
    end else if (n == 6 * p) begin
      e[0] = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic random_inputs(output logic [1:0] ty, output logic t3, output logic [2:0] n3,
                               output logic t4, output logic [2:0] n4);
    ty = 2'($urandom_range(1, 3));
    t3 = 1'($urandom_range(0, 1));
    n3 = 3'($urandom_range(1, 7));
    t4 = 1'($urandom_range(0, 1));
    n4 = 3'($urandom_range(1, 7));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    type_sel = 2'b01; tone3 = 1'b1; note3 = 3'b010; tone4 = 1'b0; note4 = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({obs_a, err_a} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_a cyc=%0d: got %b required 00000000", i, {obs_a, err_a});
      end
      n_checks++;
      if ({obs_b, err_b} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_b cyc=%0d: got %b required 00000000", i, {obs_b, err_b});
      end
    end
    start = 1'b0;
    reset = 1'b0;
    step();
  endtask

  // Plays one accepted sequence; mid>=0 pulses start with different inputs at
  // offset mid (instance b is only checked up to that point, as it is idle then).
  task automatic test_sequence(string name, logic [1:0] ty, logic t3, logic [2:0] n3,
                               logic t4, logic [2:0] n4, int mid);
    logic [23:0] syms;
    logic [6:0]  ea, eb;
    logic        prev_ok;
    logic [3:0]  seen[$];
    int          rises;
    do_reset();
    syms = build_syms(ty, t3, n3, t4, n4);
    type_sel = ty; tone3 = t3; note3 = n3; tone4 = t4; note4 = n4;
    start = 1'b1;
    rises = 0;
    prev_ok = 1'b0;
    for (int n = 0; n <= 6 * PA + 2; n++) begin
      step();
      if (n == 0) start = 1'b0;
      ea = model(n, SA, HA, LA, syms);
      n_checks++;
      if (obs_a !== ea) begin
        n_fail++;
        $display("FAIL %s_a n=%0d: got %b required %b", name, n, obs_a, ea);
      end
      n_checks++;
      if (err_a !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_a_err n=%0d: got %b required 0", name, n, err_a);
      end
      if (mid < 0 || n <= mid) begin
        eb = model(n, SB, HB, LB, syms);
        n_checks++;
        if ({obs_b, err_b} !== {eb, 1'b0}) begin
          n_fail++;
          $display("FAIL %s_b n=%0d: got %b required %b", name, n, {obs_b, err_b}, {eb, 1'b0});
        end
      end
      if (ok_a && !prev_ok) begin
        rises++;
        seen.push_back({tone_a, note_a});
      end
      prev_ok = ok_a;
      if (n == mid) begin
        start = 1'b1;
        type_sel = (ty == 2'b01) ? 2'b11 : 2'b01;
        tone3 = ~t3; note3 = (n3 == 3'd7) ? 3'd1 : n3 + 3'd1;
        tone4 = ~t4; note4 = (n4 == 3'd7) ? 3'd1 : n4 + 3'd1;
      end
      if (mid >= 0 && n == mid + 1) start = 1'b0;
    end
    n_checks++;
    if (rises != 6) begin
      n_fail++;
      $display("FAIL %s_rises: got %0d required 6", name, rises);
    end
    for (int k = 0; k < 6 && k < seen.size(); k++) begin
      n_checks++;
      if (seen[k] !== syms[k*4 +: 4]) begin
        n_fail++;
        $display("FAIL %s_symbol%0d: got %b required %b", name, k, seen[k], syms[k*4 +: 4]);
      end
    end
  endtask

  task automatic test_reject(string name, logic [1:0] ty, logic [2:0] n3, logic [2:0] n4);
    do_reset();
    type_sel = ty; tone3 = 1'b1; note3 = n3; tone4 = 1'b0; note4 = n4;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({err_a, err_b, obs_a, obs_b} !== {2'b11, 14'b0}) begin
      n_fail++;
      $display("FAIL %s_pulse: got err=%b%b a=%b b=%b required err=11 a=0 b=0",
               name, err_a, err_b, obs_a, obs_b);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if ({err_a, err_b, obs_a, obs_b} !== 16'b0) begin
        n_fail++;
        $display("FAIL %s_after n=%0d: got err=%b%b a=%b b=%b required all 0",
                 name, i, err_a, err_b, obs_a, obs_b);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] ty;
    logic       t3, t4;
    logic [2:0] n3, n4;
    do_reset();
    random_inputs(ty, t3, n3, t4, n4);
    type_sel = ty; tone3 = t3; note3 = n3; tone4 = t4; note4 = n4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 2 * PA + SA; n++) step();
    n_checks++;
    if ({ok_a, tone_a, note_a, busy_a} !== {1'b1, t3, n3, 1'b1}) begin
      n_fail++;
      $display("FAIL async_pre: got %b required %b", {ok_a, tone_a, note_a, busy_a},
               {1'b1, t3, n3, 1'b1});
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({obs_a, err_a} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_drop: got %b required 00000000", {obs_a, err_a});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    random_inputs(ty, t3, n3, t4, n4);
    test_sequence("after_reset", ty, t3, n3, t4, n4, -1);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ty;
    logic        t3, t4;
    logic [2:0]  n3, n4;
    logic [23:0] syms;
    logic [6:0]  ea, eb;
    logic        prev_ok;
    int          rises;
    do_reset();
    random_inputs(ty, t3, n3, t4, n4);
    syms = build_syms(ty, t3, n3, t4, n4);
    type_sel = ty; tone3 = t3; note3 = n3; tone4 = t4; note4 = n4;
    start = 1'b1;
    rises = 0;
    prev_ok = 1'b0;
    for (int n = 0; n < 2 * (6 * PA + 1); n++) begin
      step();
      ea = model(n % (6 * PA + 1), SA, HA, LA, syms);
      eb = model(n % (6 * PB + 1), SB, HB, LB, syms);
      n_checks++;
      if ({obs_a, err_a} !== {ea, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_a n=%0d: got %b required %b", n, {obs_a, err_a}, {ea, 1'b0});
      end
      n_checks++;
      if ({obs_b, err_b} !== {eb, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_b n=%0d: got %b required %b", n, {obs_b, err_b}, {eb, 1'b0});
      end
      if (ok_a && !prev_ok) rises++;
      prev_ok = ok_a;
    end
    start = 1'b0;
    n_checks++;
    if (rises != 12) begin
      n_fail++;
      $display("FAIL b2b_rises: got %0d required 12", rises);
    end
  endtask

  initial begin
    logic [1:0] ty;
    logic       t3, t4;
    logic [2:0] n3, n4;
    start = 1'b0; reset = 1'b0;
    type_sel = 2'b00; tone3 = 1'b0; note3 = 3'b000; tone4 = 1'b0; note4 = 3'b000;

    test_reset();
    test_sequence("past_fixed", 2'b01, 1'b1, 3'b010, 1'b0, 3'b011, -1);
    test_sequence("infinitive", 2'b10, 1'b1, 3'b010, 1'b0, 3'b011, -1);
    test_sequence("future", 2'b11, 1'b1, 3'b010, 1'b0, 3'b011, -1);
    for (int i = 0; i < 3; i++) begin
      random_inputs(ty, t3, n3, t4, n4);
      test_sequence("random", ty, t3, n3, t4, n4, -1);
    end
    test_reject("rej_type", 2'b00, 3'b010, 3'b011);
    test_reject("rej_note4", 2'b01, 3'b010, 3'b000);
    test_reject("rej_note3", 2'b11, 3'b000, 3'b011);
    test_async_reset();
    random_inputs(ty, t3, n3, t4, n4);
    test_sequence("ignore_start", ty, t3, n3, t4, n4, 3 * PA + 1);
    test_back_to_back();
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
